spi_wb_slave_regs: RTL and testbench
====================================

// Module: spi_wb_slave_regs
// PURPOSE
//  Wishbone classic slave that consumes the cycles issued by the SPI-side Wishbone master.
//  Decodes adr/sel/we into the SPI register file: TX/RX data, control, divider and slave-select.
//  Drives the configuration and GO strobe of the SPI shift engine, and returns received data.
//  Owns ack/err generation and the transfer-complete interrupt.
// PARAMETERS
//  SS_NB     8   number of slave-select lines (1..32)
//  DIV_W     16  clock-divider register width (1..32)
// PORTS
//  clk_in        in   1       system clock, all logic on posedge
//  rst_in        in   1       reset, asynchronous, active-low
//  adr_in        in   5       WB byte address; adr_in[4:2] selects the register
//  dat_in        in   32      WB write data
//  sel_in        in   4       WB byte lane enables
//  we_in         in   1       WB write enable
//  cyc_in        in   1       WB cycle
//  stb_in        in   1       WB strobe
//  dat_o         out  32      WB read data
//  ack_o         out  1       WB normal termination
//  err_o         out  1       WB error termination
//  int_o         out  1       interrupt, level
//  tx_o          out  128     {TX3,TX2,TX1,TX0} to shift engine
//  rx_in         in   128     {RX3..RX0} from shift engine
//  ctrl_o        out  14      CTRL[13:0] to shift engine
//  divider_o     out  DIV_W   SCLK divider
//  ss_o          out  SS_NB   slave-select register value
//  go_o          out  1       transfer in progress / start request (CTRL[8])
//  done_in       in   1       one-cycle pulse: shift engine finished transfer
// BEHAVIOUR
//  Reset (rst_in=0, async): ack_o=err_o=int_o=0, dat_o=0, all registers 0, go_o=0.
//  Register map (adr_in[4:2]): 0 TX0/RX0, 1 TX1/RX1, 2 TX2/RX2, 3 TX3/RX3, 4 CTRL, 5 DIVIDER, 6 SS, 7 invalid.
//  CTRL: [6:0] char_len, [7] rsvd(reads 0), [8] GO, [9] rx_neg, [10] tx_neg, [11] lsb, [12] ie, [13] ass; [31:14] read 0.
//  Access qualifies when cyc_in & stb_in & ~ack_o & ~err_o.
//  Termination: exactly one cycle after a qualifying access, ack_o or err_o high for one cycle, never both.
//  Back-to-back: stb held high -> next access qualifies the cycle after termination drops (one dead cycle).
//  Write committed on the qualifying edge, per byte lane from sel_in; sel_in=0 -> no update, still ack.
//  Read: dat_o registered on the qualifying edge, valid while ack_o high; data regs return RX, not TX.
//  DIVIDER and SS: bits above DIV_W / SS_NB ignored on write, read as 0.
//  err_o instead of ack_o when: adr_in[1:0]!=0; register index 7; write to TX0-3, CTRL or DIVIDER while go_o=1.
//  Error write has no side effect; error read returns dat_o=0.
//  Writes to SS while go_o=1 are allowed (ack).
//  GO: set by CTRL write with dat_in[8]=1 (lane 1 enabled); cleared on the edge where done_in=1.
//  done_in and a same-cycle CTRL write of GO: cannot occur (write rejected as busy -> err), done wins.
//  Interrupt: int_o set on done_in when CTRL[12]=1; cleared by any acked access; set has priority over clear in same cycle.
//  Reset asserted mid-cycle: ack_o/err_o drop immediately, go_o=0; the master must restart the cycle.
// TESTING
//  Reset, read all 7 regs -> each acks in 1 cycle with 0; read adr 5'h1C -> err_o, dat_o=0.
//  Write DIVIDER=32'hFFFF_0003 sel=4'hF, read back -> 32'h0000_0003 (DIV_W=16).
//  Write TX1=32'hA5A5_A5A5 sel=4'b0101 after TX1=0 -> tx_o[63:32]=32'h00A5_00A5; read adr 4 returns rx_in[63:32].
//  CTRL=32'h0000_1108 (ie, GO, len 8) -> go_o=1; write TX0 -> err_o, tx_o unchanged; pulse done_in -> go_o=0, int_o=1.
//  With int_o=1, read SS -> ack_o, int_o=0 next cycle; done_in coincident with ack -> int_o stays 1.
//  Unaligned adr 5'h11 write -> err_o only, CTRL unchanged; rst_in low during ack -> ack_o=0 immediately.

Source files
------------

// File: rtl/spi_wb_slave_regs.sv
// Wishbone classic slave holding the SPI register file (TX/RX, CTRL, DIVIDER, SS).
// Generates ack/err terminations, the GO strobe to the shift engine and the transfer-done interrupt.
module spi_wb_slave_regs #(
  parameter int SS_NB = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [4:0]       adr_in,
  input  logic [31:0]      dat_in,
  input  logic [3:0]       sel_in,
  input  logic             we_in,
  input  logic             cyc_in,
  input  logic             stb_in,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  output logic             err_o,
  output logic             int_o,
  output logic [127:0]     tx_o,
  input  logic [127:0]     rx_in,
  output logic [13:0]      ctrl_o,
  output logic [DIV_W-1:0] divider_o,
  output logic [SS_NB-1:0] ss_o,
  output logic             go_o,
  input  logic             done_in
);

  localparam logic [2:0] REG_CTRL = 3'd4;
  localparam logic [2:0] REG_DIV  = 3'd5;
  localparam logic [2:0] REG_SS   = 3'd6;
  localparam logic [2:0] REG_BAD  = 3'd7;
  localparam int         GO_BIT   = 8;
  localparam int         IE_BIT   = 12;

  logic [3:0][31:0]  tx_q, tx_d;
  logic [13:0]       ctrl_q, ctrl_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SS_NB-1:0]  ss_q, ss_d;
  logic [31:0]       dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              int_q, int_d;

  logic              acc, bad, wr;
  logic [2:0]        idx;
  logic [31:0]       rdata, ctrl_m, div_m, ss_m;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    acc = cyc_in & stb_in & ~ack_q & ~err_q;
    idx = adr_in[4:2];
    // TX, CTRL and DIVIDER are frozen while the shift engine is running; SS stays writable.
    bad = (adr_in[1:0] != 2'b00) | (idx == REG_BAD) |
          (we_in & ctrl_q[GO_BIT] & (idx <= REG_DIV));
    wr  = acc & we_in & ~bad;

    case (idx)
      REG_CTRL: rdata = {18'b0, ctrl_q};
      REG_DIV:  rdata = 32'(div_q);
      REG_SS:   rdata = 32'(ss_q);
      REG_BAD:  rdata = 32'b0;
      default:  rdata = rx_in[{idx[1:0], 5'b0} +: 32];
    endcase

    ctrl_m = merge_lanes({18'b0, ctrl_q}, dat_in, sel_in);
    div_m  = merge_lanes(32'(div_q), dat_in, sel_in);
    ss_m   = merge_lanes(32'(ss_q), dat_in, sel_in);

    tx_d   = tx_q;
    ctrl_d = ctrl_q;
    div_d  = div_q;
    ss_d   = ss_q;
    if (wr) begin
      case (idx)
        REG_CTRL: ctrl_d = ctrl_m[13:0] & 14'h3F7F;
        REG_DIV:  div_d  = div_m[DIV_W-1:0];
        REG_SS:   ss_d   = ss_m[SS_NB-1:0];
        REG_BAD:  ;
        default:  tx_d[idx[1:0]] = merge_lanes(tx_q[idx[1:0]], dat_in, sel_in);
      endcase
    end
    if (done_in) ctrl_d[GO_BIT] = 1'b0;

    ack_d = acc & ~bad;
    err_d = acc & bad;
    dat_d = acc ? (bad ? 32'b0 : rdata) : dat_q;

    // Set wins over the clear from an access terminating in the same cycle.
    int_d = int_q;
    if (ack_q) int_d = 1'b0;
    if (done_in & ctrl_q[IE_BIT]) int_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_q   <= '0;
      ctrl_q <= '0;
      div_q  <= '0;
      ss_q   <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      ss_q   <= ss_d;
      dat_q  <= dat_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      int_q  <= int_d;
    end
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign int_o     = int_q;
  assign tx_o      = tx_q;
  assign ctrl_o    = ctrl_q;
  assign divider_o = div_q;
  assign ss_o      = ss_q;
  assign go_o      = ctrl_q[GO_BIT];

endmodule

// File: tb/tb_spi_wb_slave_regs.sv
// Scoreboard bench for spi_wb_slave_regs: directed register scenarios plus randomized
// Wishbone traffic checked against a register-level reference model.
module tb_spi_wb_slave_regs;

  localparam int SS_NB = 8;
  localparam int DIV_W = 16;
  localparam logic [31:0] DIV_MASK = 32'h0000_FFFF;
  localparam logic [31:0] SS_MASK  = 32'h0000_00FF;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic [4:0]       adr_in = '0;
  logic [31:0]      dat_in = '0;
  logic [3:0]       sel_in = '0;
  logic             we_in = 1'b0;
  logic             cyc_in = 1'b0;
  logic             stb_in = 1'b0;
  logic [31:0]      dat_o;
  logic             ack_o, err_o, int_o, go_o;
  logic [127:0]     tx_o;
  logic [127:0]     rx_in = '0;
  logic [13:0]      ctrl_o;
  logic [DIV_W-1:0] divider_o;
  logic [SS_NB-1:0] ss_o;
  logic             done_in = 1'b0;

  spi_wb_slave_regs #(.SS_NB(SS_NB), .DIV_W(DIV_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .adr_in(adr_in), .dat_in(dat_in),
    .sel_in(sel_in), .we_in(we_in), .cyc_in(cyc_in), .stb_in(stb_in),
    .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .int_o(int_o),
    .tx_o(tx_o), .rx_in(rx_in), .ctrl_o(ctrl_o), .divider_o(divider_o),
    .ss_o(ss_o), .go_o(go_o), .done_in(done_in)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        is_ack;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  // Reference model: architectural register contents.
  logic [31:0] m_tx[4];
  logic [31:0] m_ctrl, m_div, m_ss;
  logic        m_int;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_tx[i] = '0;
    m_ctrl = '0; m_div = '0; m_ss = '0; m_int = 1'b0;
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".tx"}, tx_o, {m_tx[3], m_tx[2], m_tx[1], m_tx[0]});
    chk({tag, ".ctrl"}, 128'(ctrl_o), 128'(m_ctrl[13:0]));
    chk({tag, ".div"}, 128'(divider_o), 128'(m_div));
    chk({tag, ".ss"}, 128'(ss_o), 128'(m_ss));
    chk({tag, ".go"}, 128'(go_o), 128'(m_ctrl[8]));
    chk({tag, ".int"}, 128'(int_o), 128'(m_int));
  endtask

  // Issue one access, wait for its termination, then one dead cycle.
  task automatic wb(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input bit done_at_term);
    int    r, n;
    logic  is_err;
    exp_t  e;
    r = int'(adr[4:2]);
    is_err = (adr[1:0] != 0) || (r == 7) || (we && m_ctrl[8] && r <= 5);
    e.is_ack = !is_err;
    e.chk_dat = !we || is_err;
    e.dat = 32'h0;
    if (!we && !is_err) begin
      if (r < 4)       e.dat = rx_in[r*32 +: 32];
      else if (r == 4) e.dat = m_ctrl;
      else if (r == 5) e.dat = m_div;
      else             e.dat = m_ss;
    end
    sb.push_back(e);
    cyc_in = 1'b1; stb_in = 1'b1; we_in = we; adr_in = adr; dat_in = dat; sel_in = sel;
    n = 0;
    do begin
      @(posedge clk_in); #1; n++;
    end while (!(ack_o || err_o) && n < 4);
    if (!(ack_o || err_o)) begin
      chk("term_timeout", 128'(0), 128'(1));
      void'(sb.pop_back());
    end
    cyc_in = 1'b0; stb_in = 1'b0; we_in = 1'b0;
    if (done_at_term) done_in = 1'b1;
    @(posedge clk_in); #1;
    done_in = 1'b0;
    if (we && !is_err) begin
      if (r < 4)       m_tx[r] = lanes(m_tx[r], dat, sel);
      else if (r == 4) m_ctrl = lanes(m_ctrl, dat, sel) & 32'h3F7F;
      else if (r == 5) m_div = lanes(m_div, dat, sel) & DIV_MASK;
      else             m_ss = lanes(m_ss, dat, sel) & SS_MASK;
    end
    if (!is_err) m_int = 1'b0;
    if (done_at_term) begin
      m_ctrl[8] = 1'b0;
      if (m_ctrl[12]) m_int = 1'b1;
    end
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    @(posedge clk_in); #1;
    done_in = 1'b0;
    m_ctrl[8] = 1'b0;
    if (m_ctrl[12]) m_int = 1'b1;
  endtask

  // Monitor: every termination seen by the master is matched against the scoreboard.
  always @(negedge clk_in) begin
    if (ack_o || err_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_term", {ack_o, err_o}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_err_exclusive", 128'(ack_o & err_o), 128'(0));
        chk("term_kind", {ack_o, err_o}, {e.is_ack, !e.is_ack});
        if (e.chk_dat) chk("rdata", 128'(dat_o), 128'(e.dat));
      end
    end
  end

  initial begin
    model_reset();
    #12;
    chk("rst.ack", 128'(ack_o), 0);
    chk("rst.err", 128'(err_o), 0);
    chk("rst.dat", 128'(dat_o), 0);
    check_state("rst");
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    for (int a = 0; a < 7; a++) wb(1'b0, 5'(a * 4), 32'h0, 4'hF, 1'b0);
    wb(1'b0, 5'h1C, 32'h0, 4'hF, 1'b0);

    wb(1'b1, 5'h14, 32'hFFFF_0003, 4'hF, 1'b0);
    check_state("div_wr");
    wb(1'b0, 5'h14, 32'h0, 4'hF, 1'b0);

    wb(1'b1, 5'h04, 32'h0, 4'hF, 1'b0);
    wb(1'b1, 5'h04, 32'hA5A5_A5A5, 4'b0101, 1'b0);
    chk("tx1_lanes", 128'(tx_o[63:32]), 128'(32'h00A5_00A5));
    rx_in = {$urandom, $urandom, $urandom, $urandom};
    wb(1'b0, 5'h04, 32'h0, 4'hF, 1'b0);
    wb(1'b1, 5'h04, 32'h1234_5678, 4'h0, 1'b0);
    check_state("sel0");

    wb(1'b1, 5'h10, 32'h0000_1108, 4'hF, 1'b0);
    chk("go_set", 128'(go_o), 128'(1));
    wb(1'b1, 5'h00, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wb(1'b1, 5'h14, 32'h0000_0077, 4'hF, 1'b0);
    wb(1'b1, 5'h18, 32'h0000_005A, 4'hF, 1'b0);
    check_state("busy");
    pulse_done();
    chk("go_clr", 128'(go_o), 128'(0));
    chk("int_set", 128'(int_o), 128'(1));
    wb(1'b0, 5'h18, 32'h0, 4'hF, 1'b0);
    chk("int_clr", 128'(int_o), 128'(0));
    pulse_done();
    wb(1'b0, 5'h18, 32'h0, 4'hF, 1'b1);
    chk("int_hold", 128'(int_o), 128'(1));
    wb(1'b1, 5'h11, 32'h0000_0155, 4'hF, 1'b0);
    check_state("unaligned");

    // Reset asserted while ack is high, with a transfer in flight.
    wb(1'b1, 5'h10, 32'h0000_0100, 4'hF, 1'b0);
    cyc_in = 1'b1; stb_in = 1'b1; we_in = 1'b0; adr_in = 5'h18; sel_in = 4'hF;
    @(posedge clk_in); #1;
    chk("pre_rst_ack", 128'(ack_o), 128'(1));
    rst_in = 1'b0;
    #1;
    chk("mid_rst_ack", 128'(ack_o), 128'(0));
    chk("mid_rst_go", 128'(go_o), 128'(0));
    cyc_in = 1'b0; stb_in = 1'b0;
    model_reset();
    check_state("mid_rst");
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    for (int i = 0; i < 300; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      rx_in = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) pulse_done();
      wb(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
         $urandom_range(0, 7) == 0);
      check_state("rand");
    end

    repeat (2) @(posedge clk_in);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
